// File: rtl/door_input_cond_if.sv
// Signal bundle between the raw wall-button/limit-switch wiring and the input conditioner.
// The conditioner takes the slave side; whoever drives the raw contacts takes the master side.
interface door_input_cond_if;
    logic BTN_raw;
    logic UP_SW_raw;
    logic DN_SW_raw;
    logic Activate;
    logic UP_MAX;
    logic DN_MAX;
    logic SW_FAULT;

    modport master (
        output BTN_raw,
        output UP_SW_raw,
        output DN_SW_raw,
        input  Activate,
        input  UP_MAX,
        input  DN_MAX,
        input  SW_FAULT
    );

    modport slave (
        input  BTN_raw,
        input  UP_SW_raw,
        input  DN_SW_raw,
        output Activate,
        output UP_MAX,
        output DN_MAX,
        output SW_FAULT
    );
endinterface

// File: rtl/door_input_cond.sv
// Synchronises and debounces the wall button and both limit switches for the garage-door FSM,
// turning each accepted press into a single Activate pulse with a post-release lockout.
module door_input_cond #(
    parameter int DB_CYCLES   = 16,
    parameter int LOCK_CYCLES = 32,
    parameter int CNT_W       = 6
) (
    input logic               CLK,
    input logic               RST,
    door_input_cond_if.slave  bus
);

    localparam int NUM_IN = 3;
    localparam int IDX_BTN = 0;
    localparam int IDX_UP  = 1;
    localparam int IDX_DN  = 2;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HELD    = 2'd2,
        LOCKOUT = 2'd3
    } btnState_t;

    logic [NUM_IN-1:0]            rawIn;
    logic [NUM_IN-1:0]            sync1_q;
    logic [NUM_IN-1:0]            sync2_q;
    logic [NUM_IN-1:0]            db_q;
    logic [NUM_IN-1:0]            db_d;
    logic [NUM_IN-1:0][CNT_W-1:0] dbCnt_q;
    logic [NUM_IN-1:0][CNT_W-1:0] dbCnt_d;
    logic                         swFault_q;

    btnState_t                    state_q;
    logic [CNT_W-1:0]             lockCnt_q;
    logic                         activate_q;

    assign rawIn = {bus.DN_SW_raw, bus.UP_SW_raw, bus.BTN_raw};

    // Any sample agreeing with the current output wipes the count, so only an unbroken run flips it.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            db_d[i]    = db_q[i];
            dbCnt_d[i] = dbCnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                dbCnt_d[i] = '0;
            end else if (dbCnt_q[i] == DB_LAST) begin
                db_d[i]    = sync2_q[i];
                dbCnt_d[i] = '0;
            end else begin
                dbCnt_d[i] = dbCnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            dbCnt_q   <= '0;
            swFault_q <= 1'b0;
        end else begin
            sync1_q   <= rawIn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            dbCnt_q   <= dbCnt_d;
            swFault_q <= db_q[IDX_UP] & db_q[IDX_DN];
        end
    end

    // A press still held when lockout expires lands in HELD, so it can never produce a second pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            lockCnt_q  <= '0;
            activate_q <= 1'b0;
        end else begin
            activate_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (db_q[IDX_BTN]) begin
                        state_q    <= PULSE;
                        activate_q <= ~swFault_q;
                    end
                end
                PULSE: begin
                    state_q <= HELD;
                end
                HELD: begin
                    if (!db_q[IDX_BTN]) begin
                        state_q   <= LOCKOUT;
                        lockCnt_q <= '0;
                    end
                end
                LOCKOUT: begin
                    if (lockCnt_q == LOCK_LAST) begin
                        state_q <= db_q[IDX_BTN] ? HELD : IDLE;
                    end else begin
                        lockCnt_q <= lockCnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Activate = activate_q;
    assign bus.UP_MAX   = db_q[IDX_UP];
    assign bus.DN_MAX   = db_q[IDX_DN];
    assign bus.SW_FAULT = swFault_q;

endmodule

// File: tb/tb_door_input_cond.sv
// Directed bench for door_input_cond with DB_CYCLES=4, LOCK_CYCLES=8; edge numbers below count
// from the first edge that samples the new raw level.
module tb_door_input_cond;

    logic clk = 1'b0;
    logic rstN;
    int   vecCount  = 0;
    int   missCount = 0;

    door_input_cond_if bus ();

    door_input_cond #(
        .DB_CYCLES   (4),
        .LOCK_CYCLES (8),
        .CNT_W       (6)
    ) dut (
        .CLK (clk),
        .RST (rstN),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN          = 1'b0;
        bus.BTN_raw   = 1'b0;
        bus.UP_SW_raw = 1'b0;
        bus.DN_SW_raw = 1'b0;
        nextEdge();
        nextEdge();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        logic [3:0] want;
        rstN          = 1'b0;
        bus.BTN_raw   = 1'b1;
        bus.UP_SW_raw = 1'b1;
        bus.DN_SW_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextEdge();
            got = {bus.Activate, bus.UP_MAX, bus.DN_MAX, bus.SW_FAULT};
            vecCount++;
            if (got !== 4'b0000) begin
                missCount++;
                $display("[TB] FAIL reset_hold edge=%0d got {Act,UP,DN,FLT}=%b want 0000", i, got);
            end
        end
        rstN = 1'b1;
        // Button also held, so its pulse fires at edge 7, one edge before the fault flag blocks it.
        for (int k = 1; k <= 9; k++) begin
            nextEdge();
            got  = {bus.Activate, bus.UP_MAX, bus.DN_MAX, bus.SW_FAULT};
            want = {k == 7, k >= 6, k >= 6, k >= 7};
            vecCount++;
            if (got !== want) begin
                missCount++;
                $display("[TB] FAIL reset_release edge=%0d got {Act,UP,DN,FLT}=%b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        doReset();
        bus.BTN_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nextEdge();
            if (bus.Activate === 1'b1) pulses++;
            vecCount++;
            if (bus.Activate !== (k == 6)) begin
                missCount++;
                $display("[TB] FAIL clean_press edge=%0d got Activate=%b want %b", k, bus.Activate, k == 6);
            end
        end
        vecCount++;
        if (pulses !== 1) begin
            missCount++;
            $display("[TB] FAIL clean_press_count got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        logic lvl;
        doReset();
        for (int k = 0; k < 30; k++) begin
            lvl = (k < 3) || (k >= 6 && k < 9) || (k >= 12);
            bus.BTN_raw = lvl;
            nextEdge();
            vecCount++;
            if (bus.Activate !== (k == 18)) begin
                missCount++;
                $display("[TB] FAIL bounce edge=%0d got Activate=%b want %b", k, bus.Activate, k == 18);
            end
        end
    endtask

    task automatic test_lockout();
        logic lvl;
        logic want;
        doReset();
        // Release at 10 drops btn_db at 15; re-press at 18 is still held when lockout ends at 24.
        for (int k = 0; k < 71; k++) begin
            lvl  = (k < 10) || (k >= 18 && k < 41) || (k >= 56);
            want = (k == 6) || (k == 62);
            bus.BTN_raw = lvl;
            nextEdge();
            vecCount++;
            if (bus.Activate !== want) begin
                missCount++;
                $display("[TB] FAIL lockout edge=%0d got Activate=%b want %b", k, bus.Activate, want);
            end
        end
    endtask

    task automatic test_limit_debounce();
        logic [2:0] got;
        logic [2:0] want;
        doReset();
        for (int k = 0; k < 15; k++) begin
            bus.UP_SW_raw = (k < 3) || (k >= 5);
            nextEdge();
            got  = {bus.UP_MAX, bus.DN_MAX, bus.SW_FAULT};
            want = {k >= 10, 1'b0, 1'b0};
            vecCount++;
            if (got !== want) begin
                missCount++;
                $display("[TB] FAIL limit_debounce edge=%0d got {UP,DN,FLT}=%b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_fault_suppress();
        logic [3:0] got;
        logic [3:0] want;
        doReset();
        for (int k = 0; k < 61; k++) begin
            bus.UP_SW_raw = 1'b1;
            bus.DN_SW_raw = (k < 26);
            bus.BTN_raw   = (k >= 10 && k < 26) || (k >= 45);
            nextEdge();
            got  = {bus.Activate, bus.UP_MAX, bus.DN_MAX, bus.SW_FAULT};
            want = {k == 51, k >= 5, k >= 5 && k < 31, k >= 6 && k < 32};
            vecCount++;
            if (got !== want) begin
                missCount++;
                $display("[TB] FAIL fault_suppress edge=%0d got {Act,UP,DN,FLT}=%b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_reset_midway();
        doReset();
        bus.BTN_raw = 1'b1;
        for (int k = 0; k < 4; k++) nextEdge();
        doReset();
        bus.BTN_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            nextEdge();
            vecCount++;
            if (bus.Activate !== (k == 6)) begin
                missCount++;
                $display("[TB] FAIL reset_midway edge=%0d got Activate=%b want %b", k, bus.Activate, k == 6);
            end
        end
    endtask

    initial begin
        rstN          = 1'b0;
        bus.BTN_raw   = 1'b0;
        bus.UP_SW_raw = 1'b0;
        bus.DN_SW_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_lockout();
        test_limit_debounce();
        test_fault_suppress();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/door_input_cond.md
# door_input_cond

Input conditioner sitting directly upstream of the garage-door control FSM. Synchronises and debounces the raw wall push-button and the two raw limit switches. Produces the clean single-cycle `Activate` pulse and stable `UP_MAX`/`DN_MAX` levels that the door FSM consumes, plus a fault flag when both limits read closed.

## Interface
- `DB_CYCLES`, default 16: consecutive synchronised cycles a new input level must hold before the debounced output follows. Legal range 2 to 2^CNT_W.
- `LOCK_CYCLES`, default 32: cycles after button release during which a new press is ignored. Legal range 1 to 2^CNT_W.
- `CNT_W`, default 6: width of the debounce and lockout counters.
- `CLK`, input, 1: single system clock; all state updates on its rising edge.
- `RST`, input, 1: synchronous, active-low reset, sampled on rising edge of `CLK`.
- `BTN_raw`, input, 1: asynchronous push-button; 1 = pressed.
- `UP_SW_raw`, input, 1: asynchronous upper limit switch; 1 = closed.
- `DN_SW_raw`, input, 1: asynchronous lower limit switch; 1 = closed.
- `Activate`, output, 1: registered one-cycle pulse per accepted press.
- `UP_MAX`, output, 1: registered, debounced upper limit level.
- `DN_MAX`, output, 1: registered, debounced lower limit level.
- `SW_FAULT`, output, 1: registered; 1 while debounced `UP_MAX` and `DN_MAX` are both 1.

## Operation
- Synchroniser: each raw input passes through its own 2-flop synchroniser, `s1` then `s2`.
- Debouncer: three identical instances, one each for button, up, and down. Each has a counter `cnt` and an output `db`. On each edge:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- Any glitch back to the old level before the count completes clears `cnt`. No partial credit is kept.
- `UP_MAX` and `DN_MAX` are the up and down `db` flops themselves.
- `SW_FAULT <= UP_MAX & DN_MAX`, one register stage.
- Button FSM states IDLE, PULSE, HELD, LOCKOUT, driven from the button `db` (`btn_db`):
  - IDLE: if `btn_db == 1`, go to PULSE; else stay.
  - PULSE: always go to HELD. This state lasts one cycle.
  - HELD: if `btn_db == 0`, go to LOCKOUT and clear the lockout counter; else stay.
  - LOCKOUT: increment the lockout counter each cycle. At count `LOCK_CYCLES-1`, go to IDLE if `btn_db == 0`, or to HELD if `btn_db == 1`, so a press held across lockout never pulses.
  - Unused encodings go to IDLE.
- `Activate` is registered:
  - It is set to 1 on the edge that moves the FSM IDLE to PULSE, only if `SW_FAULT` is 0 at that edge.
  - It is cleared on every other edge.
  - A press accepted during a fault consumes the press (PULSE, then HELD) with no pulse.
- A button press does not affect `UP_MAX`/`DN_MAX`, and a limit switch does not affect the button path. All three debouncers run independently and concurrently.

## Timing
- Reset (`RST == 0` at an edge): all synchroniser flops, `db` flops and counters go to 0, the FSM goes to IDLE, and `Activate`, `UP_MAX`, `DN_MAX`, `SW_FAULT` are all 0.
- Reset asserted mid-debounce or mid-lockout discards all progress. The first edge after release behaves as after power-up.
- A switch already closed at reset appears on its output DB_CYCLES+1 edges after the first post-reset edge that samples it.
- Limit latency: raw level stable from sampling edge E (into `s1`) until the output changes at edge E+1+DB_CYCLES.
- Fault latency: `SW_FAULT` follows at E+2+DB_CYCLES when that change completes the both-closed condition.
- Button latency:
  - `btn_db` rises at edge E+1+DB_CYCLES.
  - The FSM enters PULSE and `Activate` goes to 1 at E+2+DB_CYCLES.
  - `Activate` returns to 0 at E+3+DB_CYCLES.
  - `Activate` is never high for two consecutive cycles.
- Minimum spacing between two `Activate` pulses:
  - Lower bound: DB_CYCLES of hold, release debounce of DB_CYCLES, LOCK_CYCLES of lockout, then press debounce again.
  - The bench checks that no pulse occurs before release debounce plus LOCK_CYCLES have elapsed.
- Simultaneous events: both limit switches changing on the same edge debounce independently. Equal-length stable periods flip both outputs on the same edge.

## Test plan
All scenarios use DB_CYCLES=4, LOCK_CYCLES=8.
- Reset: hold `RST`=0 for 3 edges with all raw inputs 1 -> all outputs 0 during reset. After release, `UP_MAX`=`DN_MAX`=1 at the 6th post-reset edge and `SW_FAULT`=1 at the 7th.
- Clean press: `BTN_raw` rises before edge 0 and is held 20 cycles -> `Activate`=1 only between edges 6 and 7, with exactly one pulse.
- Bounce rejection: `BTN_raw` toggles 1,0,1,0 with a 3-cycle period, then stays 1 -> no pulse during bouncing. Exactly one pulse occurs 6 edges after the final rising sample.
- Lockout: press for 10 cycles, release, then re-press 3 cycles after `btn_db` falls and hold -> no second pulse while in LOCKOUT. The FSM goes to HELD at lockout end and `Activate` stays 0 until release and a fresh press.
- Limit debounce: `UP_SW_raw` goes 1, returns to 0 after 3 cycles, then goes 1 steady -> `UP_MAX` stays 0 through the glitch and rises 5 edges after the steady sample. `DN_MAX` is unaffected.
- Fault suppression: both limits debounced to 1 (`SW_FAULT`=1), then a clean press -> FSM passes PULSE to HELD but `Activate` stays 0. After `DN_SW_raw` is released and `SW_FAULT` clears, the next press pulses normally.
